mem_stage: RTL and testbench

//  Memory-access stage of the 5-stage sram_cpu pipeline, between EXE and WB.

---
 rtl/mem_stage_pkg.sv | 68 ++++++
 rtl/mem_align.sv | 56 +++++
 rtl/mem_stage.sv | 150 +++++++++++++++
 tb/tb_mem_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, size/exception codes,
// FSM state encodings and the EXE->MEM / MEM->WB bus layouts.
package mem_stage_pkg;

  localparam int unsigned EXE_MEM_W = 166;
  localparam int unsigned MEM_WB_W  = 161;
  localparam int unsigned PASS_W    = 95;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned WEN_W     = 4;
  localparam int unsigned WDEST_W   = 5;
  localparam int unsigned LAT_CNT_W = 2;

  // Access size codes; 2'b11 behaves as a word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // addr_exc codes as consumed by WB.
  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ADES  = 2'b01;
  localparam logic [1:0] EXC_ADEL  = 2'b10;
  localparam logic [1:0] EXC_FETCH = 2'b11;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Pass-through field carried from EXE to WB.
  typedef struct packed {
    logic [57:0] hi;
    logic [4:0]  wdest;
    logic [31:0] pc;
  } pass_t;

  typedef struct packed {
    logic        exc_in;
    logic        fetch_adel;
    logic        load;
    logic        store;
    logic        sign;
    logic [1:0]  size;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    pass_t       pass;
  } exe_mem_bus_t;

  // Field order is the one WB unpacks.
  typedef struct packed {
    logic [57:0] pass_hi;
    logic [31:0] mem_result;
    logic [4:0]  wdest;
    logic [1:0]  addr_exc;
    logic [31:0] badvaddr;
    logic [31:0] pc;
  } mem_wb_bus_t;

  // Word needs a==0, half needs a[0]==0, byte is always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic mis;
    if (size == SIZE_BYTE)      mis = 1'b0;
    else if (size == SIZE_HALF) mis = a[0];
    else                        mis = (a != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the MEM stage.
//  size, sign, addr_lo  : access size code, load sign-extend, address low bits
//  store_data, rdata    : register store data, raw SRAM read word
//  st_wen_c, st_wdata_c : store byte enables and lane-replicated store data
//  ld_value_c           : extracted and extended load value
//  misaligned_c         : address not aligned to the access size
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [WEN_W-1:0]  st_wen_c,
  output logic [DATA_W-1:0] st_wdata_c,
  output logic [DATA_W-1:0] ld_value_c,
  output logic              misaligned_c
);

  logic [DATA_W-1:0] shifted;

  // Store lanes: data replicated so every enabled lane sees the right byte.
  always_comb begin
    st_wen_c   = 4'b1111;
    st_wdata_c = store_data;
    case (size)
      SIZE_BYTE: begin
        st_wen_c   = 4'b0001 << addr_lo;
        st_wdata_c = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        st_wen_c   = 4'b0011 << addr_lo;
        st_wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        st_wen_c   = 4'b1111;
        st_wdata_c = store_data;
      end
    endcase
  end

  // Load extract: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    ld_value_c = rdata;
    case (size)
      SIZE_BYTE: ld_value_c = {{24{sign & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: ld_value_c = {{16{sign & shifted[15]}}, shifted[15:0]};
      default:   ld_value_c = rdata;
    endcase
  end

  assign misaligned_c = is_misaligned(size, addr_lo);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between EXE and WB of the sram_cpu pipeline.
//  clk, reset              : clock, synchronous active-high reset
//  MEM_valid, EXE_MEM_bus_r: instruction from EXE, held until MEM_over
//  cancel                  : flush from WB, kills the instruction in MEM
//  data_sram_*             : data-SRAM port (reads return SRAM_LAT cycles later)
//  MEM_over, MEM_allow_in  : completion strobe / ready for next instruction
//  MEM_WB_bus, MEM_wdest   : result bus to WB, destination for hazard checks
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic                 cancel,
  output logic                 data_sram_en,
  output logic [WEN_W-1:0]     data_sram_wen,
  output logic [ADDR_W-1:0]    data_sram_addr,
  output logic [DATA_W-1:0]    data_sram_wdata,
  input  logic [DATA_W-1:0]    data_sram_rdata,
  output logic                 MEM_over,
  output logic                 MEM_allow_in,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [WDEST_W-1:0]   MEM_wdest
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(SRAM_LAT - 1);

  exe_mem_bus_t          in_bus;
  mem_wb_bus_t           wb_bus;
  logic [1:0]            state_q, state_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]     ld_data_q, ld_data_d;
  logic [WEN_W-1:0]      st_wen_c;
  logic [DATA_W-1:0]     st_wdata_c;
  logic [DATA_W-1:0]     ld_value_c;
  logic                  misaligned_c;
  logic [1:0]            addr_exc_c;
  logic                  acc_ok_c;
  logic [DATA_W-1:0]     mem_result_c;

  assign in_bus = exe_mem_bus_t'(EXE_MEM_bus_r);

  mem_align u_align (
    .size         (in_bus.size),
    .sign         (in_bus.sign),
    .addr_lo      (in_bus.exe_result[1:0]),
    .store_data   (in_bus.store_data),
    .rdata        (data_sram_rdata),
    .st_wen_c     (st_wen_c),
    .st_wdata_c   (st_wdata_c),
    .ld_value_c   (ld_value_c),
    .misaligned_c (misaligned_c)
  );

  // Address exception code; a fetch fault outranks any data fault.
  always_comb begin
    addr_exc_c = EXC_NONE;
    if (in_bus.fetch_adel)                      addr_exc_c = EXC_FETCH;
    else if (in_bus.load  && misaligned_c)      addr_exc_c = EXC_ADEL;
    else if (in_bus.store && misaligned_c)      addr_exc_c = EXC_ADES;
  end

  assign acc_ok_c = MEM_valid & ~cancel & ~in_bus.exc_in & ~in_bus.fetch_adel
                  & (addr_exc_c == EXC_NONE);

  // Next-state and SRAM/handshake outputs.
  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    ld_data_d     = ld_data_q;
    data_sram_en  = 1'b0;
    data_sram_wen = '0;
    MEM_over      = 1'b0;
    MEM_allow_in  = 1'b0;
    mem_result_c  = in_bus.exe_result;
    case (state_q)
      ST_IDLE: begin
        MEM_allow_in = 1'b1;
        if (in_bus.load && acc_ok_c) begin
          data_sram_en = 1'b1;
          MEM_allow_in = 1'b0;
          lat_cnt_d    = LAT_INIT;
          state_d      = ST_WAIT;
        end else begin
          // Non-memory, excepted or posted-store instructions finish now.
          MEM_over = MEM_valid & ~cancel;
          if (in_bus.store && acc_ok_c) begin
            data_sram_en  = 1'b1;
            data_sram_wen = st_wen_c;
          end
        end
      end
      ST_WAIT: begin
        if (cancel) begin
          // Fixed-latency SRAM: the stale read simply goes unsampled.
          state_d   = ST_IDLE;
          lat_cnt_d = '0;
          ld_data_d = '0;
        end else if (lat_cnt_q == '0) begin
          ld_data_d = ld_value_c;
          state_d   = ST_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end
      end
      ST_DONE: begin
        MEM_allow_in = 1'b1;
        state_d      = ST_IDLE;
        if (cancel) begin
          ld_data_d = '0;
        end else begin
          MEM_over     = 1'b1;
          mem_result_c = ld_data_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      ld_data_q <= ld_data_d;
    end
  end

  // Result bus in WB field order.
  always_comb begin
    wb_bus.pass_hi    = in_bus.pass.hi;
    wb_bus.mem_result = mem_result_c;
    wb_bus.wdest      = in_bus.pass.wdest;
    wb_bus.addr_exc   = addr_exc_c;
    wb_bus.badvaddr   = in_bus.exe_result;
    wb_bus.pc         = in_bus.pass.pc;
  end

  assign MEM_WB_bus      = wb_bus;
  assign data_sram_addr  = in_bus.exe_result;
  assign data_sram_wdata = st_wdata_c;
  assign MEM_wdest       = in_bus.pass.wdest & {WDEST_W{MEM_valid}};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage; two instances, SRAM_LAT=1 and SRAM_LAT=3.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int N_RAND = 300;

  typedef struct {
    int                  cyc;
    logic [MEM_WB_W-1:0] bus;
    logic                en;
    logic [3:0]          wen;
    logic [31:0]         wdata;
    logic                chk_wd;
    logic [31:0]         addr;
  } exp_t;

  logic clk;
  int   cyc;
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    n_vec = 0;
    n_err = 0;
  end

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic                 reset, MEM_valid, cancel;
    logic [EXE_MEM_W-1:0] bus_in;
    logic                 en, over, allow;
    logic [3:0]           wen;
    logic [31:0]          sram_addr, wdata, rdata;
    logic [MEM_WB_W-1:0]  wb;
    logic [4:0]           wdest;
    logic                 chk_rst, chk_idle, chk_end, tmo, done;
    logic                 poke_en;
    int                   poke_idx;
    logic [31:0]          poke_val;
    logic [31:0]          sram    [0:63];
    logic [31:0]          ref_mem [0:63];
    logic [31:0]          rd_pipe [0:2];
    exp_t                 q[$];

    mem_stage #(.SRAM_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(bus_in),
      .cancel(cancel), .data_sram_en(en), .data_sram_wen(wen),
      .data_sram_addr(sram_addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
      .MEM_over(over), .MEM_allow_in(allow), .MEM_WB_bus(wb), .MEM_wdest(wdest)
    );

    // Data SRAM: byte-enabled writes, reads returned LAT cycles after request.
    always @(posedge clk) begin
      if (poke_en) sram[poke_idx] <= poke_val;
      if (en && wen != 4'b0000)
        for (int i = 0; i < 4; i++)
          if (wen[i]) sram[sram_addr[7:2]][8*i +: 8] <= wdata[8*i +: 8];
      rd_pipe[0] <= (en && wen == 4'b0000) ? sram[sram_addr[7:2]] : 32'hDEADBEEF;
      rd_pipe[1] <= rd_pipe[0];
      rd_pipe[2] <= rd_pipe[1];
    end
    assign rdata = rd_pipe[LAT-1];

    task automatic chk(input string nm, input logic [MEM_WB_W-1:0] act,
                       input logic [MEM_WB_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL lat%0d %s cyc=%0d got=%h want=%h", LAT, nm, cyc, act, exp);
      end
    endtask

    // Monitor: every cycle invariants, plus scoreboard pop on each MEM_over.
    always @(negedge clk) begin
      exp_t e;
      chk("en_under_cancel", MEM_WB_W'(en & cancel), MEM_WB_W'(0));
      chk("wdest", MEM_WB_W'(wdest), MEM_WB_W'(MEM_valid ? bus_in[36:32] : 5'd0));
      if (chk_rst) begin
        chk("rst_en", MEM_WB_W'(en), MEM_WB_W'(0));
        chk("rst_wen", MEM_WB_W'(wen), MEM_WB_W'(0));
        chk("rst_over", MEM_WB_W'(over), MEM_WB_W'(0));
        chk("rst_allow", MEM_WB_W'(allow), MEM_WB_W'(1));
      end
      if (chk_idle) chk("idle_after_kill", MEM_WB_W'(allow), MEM_WB_W'(1));
      if (tmo)      chk("over_timeout", MEM_WB_W'(over), MEM_WB_W'(1));
      if (chk_end)  chk("queue_empty", MEM_WB_W'(q.size()), MEM_WB_W'(0));
      if (over) begin
        if (q.size() == 0) begin
          chk("spurious_over", MEM_WB_W'(over), MEM_WB_W'(0));
        end else begin
          e = q.pop_front();
          chk("over_cycle", MEM_WB_W'(cyc), MEM_WB_W'(e.cyc));
          chk("wb_bus", wb, e.bus);
          chk("sram_en", MEM_WB_W'(en), MEM_WB_W'(e.en));
          chk("sram_wen", MEM_WB_W'(wen), MEM_WB_W'(e.wen));
          if (e.chk_wd) chk("sram_wdata", MEM_WB_W'(wdata), MEM_WB_W'(e.wdata));
          chk("sram_addr", MEM_WB_W'(sram_addr), MEM_WB_W'(e.addr));
          chk("allow_at_over", MEM_WB_W'(allow), MEM_WB_W'(1));
        end
      end
    end

    task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1;
        MEM_valid = 1'b0; cancel = 1'b0; reset = 1'b0;
        chk_idle = 1'b0; tmo = 1'b0; poke_en = 1'b0;
        bus_in = EXE_MEM_W'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
      @(posedge clk); #1;
      MEM_valid = 1'b0; chk_idle = 1'b0; tmo = 1'b0;
      poke_en = 1'b1; poke_idx = int'(a[7:2]); poke_val = v;
      ref_mem[a[7:2]] = v;
    endtask

    // One instruction: model its outcome, push the expectation, drive it.
    // cancel_at/reset_at: -1 none, -2 pick a random cycle of its lifetime.
    task automatic issue(input logic ld, input logic st, input logic sgn,
                         input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] sd, input logic exc, input logic fad,
                         input int cancel_at_i, input int reset_at_i);
      logic [94:0] pass;
      logic [1:0]  a, aexc;
      logic        mis, acc, killed, seen;
      logic [31:0] res, ewd;
      logic [3:0]  ewen;
      int unsigned v;
      int          n, lat, cancel_at, reset_at, idx;
      exp_t        e;
      pass = 95'({$urandom, $urandom, $urandom});
      a    = addr[1:0];
      idx  = int'(addr[7:2]);
      n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      mis  = (int'(a) % n) != 0;
      aexc = fad ? 2'b11 : (mis && ld) ? 2'b10 : (mis && st) ? 2'b01 : 2'b00;
      acc  = (ld || st) && !exc && !fad && !mis;
      lat  = (ld && acc) ? LAT + 1 : 0;
      cancel_at = (cancel_at_i == -2) ? int'($urandom_range(lat, 0)) : cancel_at_i;
      reset_at  = reset_at_i;
      if (reset_at_i == -2) reset_at = (lat >= 2) ? int'($urandom_range(lat - 1, 1)) : -1;
      killed = (cancel_at >= 0 && cancel_at <= lat) || (reset_at >= 0 && reset_at <= lat);

      res  = addr;
      ewen = 4'b0000;
      ewd  = 32'h0;
      if (ld && acc) begin
        v = ref_mem[idx] >> (8 * int'(a));
        if (n < 4) begin
          v = v % (32'd1 << (8 * n));
          if (sgn && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        end
        res = v;
      end
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = sd[8*(i % n) +: 8];
      if (st && acc && !killed)
        for (int i = 0; i < n; i++) begin
          ref_mem[idx][8*(int'(a) + i) +: 8] = sd[8*i +: 8];
          ewen[int'(a) + i] = 1'b1;
        end

      @(posedge clk); #1;
      poke_en = 1'b0; chk_idle = 1'b0; tmo = 1'b0;
      bus_in    = {exc, fad, ld, st, sgn, sz, sd, addr, pass};
      MEM_valid = 1'b1;
      cancel    = (cancel_at == 0);
      reset     = (reset_at == 0);
      if (!killed) begin
        e.cyc    = cyc + lat;
        e.bus    = {pass[94:37], res, pass[36:32], aexc, addr, pass[31:0]};
        e.en     = st && acc;
        e.wen    = ewen;
        e.wdata  = ewd;
        e.chk_wd = st && acc;
        e.addr   = addr;
        q.push_back(e);
      end
      seen = 1'b0;
      for (int k = 0; k <= lat + 4; k++) begin
        @(negedge clk);
        if (killed && (k == cancel_at || k == reset_at)) break;
        if (!killed && over) begin
          seen = 1'b1;
          break;
        end
        @(posedge clk); #1;
        cancel = (k + 1 == cancel_at);
        reset  = (k + 1 == reset_at);
      end
      if (killed) begin
        @(posedge clk); #1;
        MEM_valid = 1'b0; cancel = 1'b0; reset = 1'b0; chk_idle = 1'b1;
      end else if (!seen) begin
        @(posedge clk); #1;
        MEM_valid = 1'b0; cancel = 1'b0; tmo = 1'b1;
        q.delete();
      end
    endtask

    initial begin
      logic [1:0] sz;
      int         kind, r, ca, ra;
      reset = 1'b1; MEM_valid = 1'b0; cancel = 1'b0; bus_in = '0;
      chk_rst = 1'b0; chk_idle = 1'b0; chk_end = 1'b0; tmo = 1'b0; done = 1'b0;
      poke_en = 1'b0; poke_idx = 0; poke_val = 32'h0;
      for (int i = 0; i < 64; i++) begin
        @(posedge clk); #1;
        poke_en = 1'b1; poke_idx = i; poke_val = $urandom; ref_mem[i] = poke_val;
      end
      @(posedge clk); #1;
      poke_en = 1'b0; chk_rst = 1'b1;
      @(posedge clk); #1;
      chk_rst = 1'b0; reset = 1'b0;

      issue(1'b0, 1'b1, 1'b0, 2'b10, 32'h100, 32'hA1B2C3D4, 1'b0, 1'b0, -1, -1); // sw
      issue(1'b0, 1'b1, 1'b0, 2'b00, 32'h103, 32'h000000EE, 1'b0, 1'b0, -1, -1); // sb
      poke(32'h100, 32'h12F45678);
      issue(1'b1, 1'b0, 1'b1, 2'b00, 32'h102, 32'h0, 1'b0, 1'b0, -1, -1);         // lb
      poke(32'h100, 32'h80015678);
      issue(1'b1, 1'b0, 1'b0, 2'b01, 32'h102, 32'h0, 1'b0, 1'b0, -1, -1);         // lhu
      issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h101, 32'h0, 1'b0, 1'b0, -1, -1);         // lw AdEL
      issue(1'b0, 1'b1, 1'b0, 2'b01, 32'h007, 32'h1234, 1'b0, 1'b0, -1, -1);      // sh AdES
      issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h140, 32'h0, 1'b0, 1'b0, 1, -1);          // lw cancelled in WAIT
      issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h144, 32'h0, 1'b0, 1'b0, -1, -1);         // next lw
      issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h148, 32'h0, 1'b0, 1'b0, -1, 1);          // reset in WAIT
      gap(2);
      issue(1'b0, 1'b0, 1'b0, 2'b10, 32'h1F0, 32'h0, 1'b0, 1'b1, -1, -1);         // fetch AdEL

      for (int i = 0; i < N_RAND; i++) begin
        kind = int'($urandom % 3);
        sz   = 2'($urandom);
        r    = int'($urandom % 16);
        ca   = (r == 0) ? -2 : -1;
        ra   = (r == 1) ? -2 : -1;
        issue(kind == 1, kind == 2, 1'($urandom), sz, 32'h100 + ($urandom % 256),
              $urandom, ($urandom % 12) == 0, ($urandom % 12) == 0, ca, ra);
        if ($urandom % 4 == 0) gap(1 + int'($urandom % 2));
      end

      gap(3);
      @(posedge clk); #1;
      chk_end = 1'b1;
      @(posedge clk); #1;
      chk_end = 1'b0;
      done    = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(lane[0].done && lane[1].done) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 50000) begin
      n_err++;
      $display("FAIL run_timeout cycles=%0d limit=50000", t);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
